memory_access_sequencer: RTL and testbench

Processor-side initiator for the data RAM's MFC (memory-function-complete) handshake. It accepts one load/store request from the datapath at a time, with the address taken from RZ or PC. It drives the RAM address, the read/write select, the enable and the write data, then waits for MFC. On completion it latches read data into a memory data register and releases the pipeline stall. A cycle counter bounds the wait and reports a bus error if MFC never arrives.

---
 rtl/memory_access_sequencer_if.sv | 45 ++++
 rtl/memory_access_sequencer.sv | 178 +++++++++++++++++
 tb/tb_memory_access_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/memory_access_sequencer_if.sv
// rtl/memory_access_sequencer_if.sv - request and RAM bus bundle for the memory access sequencer
//
// Purpose: groups the datapath request handshake and the data RAM MFC bus.
// Modports:
//   master - the sequencer: samples Req_* and Mem_Data_In/Mem_MFC, drives
//            Req_Done/Req_Error/Read_Data/Stall and the Mem_* strobes.
//   slave  - the environment (datapath + RAM): the mirror image.
// Signals:
//   Req_Valid/Req_Write/Req_Address/Req_Data  request (level, held until Req_Done)
//   Req_Done/Req_Error                         completion pulses
//   Read_Data                                  memory data register
//   Stall                                      pipeline hold
//   Mem_Address/Mem_Read_H_Write_L/Mem_Enable/Mem_Data_Out  RAM command
//   Mem_Data_In/Mem_MFC                        RAM response

interface memory_access_sequencer_if;
  logic        Req_Valid;
  logic        Req_Write;
  logic [31:0] Req_Address;
  logic [31:0] Req_Data;
  logic        Req_Done;
  logic        Req_Error;
  logic [31:0] Read_Data;
  logic        Stall;
  logic [31:0] Mem_Address;
  logic        Mem_Read_H_Write_L;
  logic        Mem_Enable;
  logic [31:0] Mem_Data_Out;
  logic [31:0] Mem_Data_In;
  logic        Mem_MFC;

  modport master (
    input  Req_Valid, Req_Write, Req_Address, Req_Data,
    output Req_Done, Req_Error, Read_Data, Stall,
    output Mem_Address, Mem_Read_H_Write_L, Mem_Enable, Mem_Data_Out,
    input  Mem_Data_In, Mem_MFC
  );

  modport slave (
    output Req_Valid, Req_Write, Req_Address, Req_Data,
    input  Req_Done, Req_Error, Read_Data, Stall,
    input  Mem_Address, Mem_Read_H_Write_L, Mem_Enable, Mem_Data_Out,
    output Mem_Data_In, Mem_MFC
  );
endinterface

// File: rtl/memory_access_sequencer.sv
// rtl/memory_access_sequencer.sv - processor-side initiator for the data RAM MFC handshake
//
// Purpose: accepts one load/store at a time, drives the RAM command from
// captured request registers, waits for MFC (bounded by TIMEOUT_CYCLES),
// latches load data into the memory data register and pulses Req_Done.
// Ports:
//   Clock    - single rising-edge clock
//   Reset_L  - synchronous active-low reset
//   bus      - memory_access_sequencer_if.master (request + RAM signals)
// Parameters:
//   TIMEOUT_CYCLES - WAIT cycles before an access is aborted with Req_Error (1..255)

module memory_access_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                       Clock,
  input  logic                       Reset_L,
  memory_access_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Counter value seen on the last permitted WAIT cycle.
  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  state_t      state_d;

  logic        write_q;
  logic [31:0] address_q;
  logic [31:0] data_q;
  logic [31:0] read_data_q;
  logic [7:0]  count_q;
  logic        error_q;

  logic        accept;
  logic        wait_timeout;
  logic        wait_mfc;

  assign accept       = (state_q == S_IDLE) && bus.Req_Valid;
  assign wait_mfc     = (state_q == S_WAIT) && bus.Mem_MFC;
  // MFC has priority: a timeout only counts when MFC is absent.
  assign wait_timeout = (state_q == S_WAIT) && !bus.Mem_MFC && (count_q == LAST_COUNT);

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (!Reset_L) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.Req_Valid) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_mfc || wait_timeout) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Request capture. Inputs are only looked at on the IDLE->ISSUE edge so
  // the RAM command stays stable whatever the requester does afterwards.
  // Store data is zeroed for loads so Mem_Data_Out reads 0 on a load.
  // ---------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (!Reset_L) begin
      write_q   <= 1'b0;
      address_q <= '0;
      data_q    <= '0;
    end else if (accept) begin
      write_q   <= bus.Req_Write;
      address_q <= bus.Req_Address;
      data_q    <= bus.Req_Write ? bus.Req_Data : 32'd0;
    end
  end

  // ---------------------------------------------------------------------
  // Wait counter: cleared in ISSUE, counts MFC-low WAIT cycles, and
  // saturates so it can never wrap back below LAST_COUNT.
  // ---------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (!Reset_L) begin
      count_q <= '0;
    end else if (state_q == S_ISSUE) begin
      count_q <= '0;
    end else if ((state_q == S_WAIT) && !bus.Mem_MFC && (count_q != 8'hFF)) begin
      count_q <= count_q + 8'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Error flag: set on the timeout exit from WAIT, cleared when the next
  // request is accepted so it only ever qualifies its own DONE cycle.
  // ---------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (!Reset_L) begin
      error_q <= 1'b0;
    end else if (accept) begin
      error_q <= 1'b0;
    end else if (wait_timeout) begin
      error_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Memory data register: only a successful load updates it.
  // ---------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (!Reset_L) begin
      read_data_q <= '0;
    end else if (wait_mfc && !write_q) begin
      read_data_q <= bus.Mem_Data_In;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: decoded from state and captured registers only. Stall is the
  // single combinational path from an input (Req_Valid), so the pipeline
  // freezes in the same cycle it raises a request.
  // ---------------------------------------------------------------------
  always_comb begin
    bus.Mem_Enable         = 1'b0;
    bus.Mem_Read_H_Write_L = 1'b1;
    bus.Mem_Address        = address_q;
    bus.Mem_Data_Out       = data_q;
    bus.Req_Done           = 1'b0;
    bus.Req_Error          = 1'b0;
    bus.Read_Data          = read_data_q;
    bus.Stall              = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.Stall = bus.Req_Valid;
      end
      S_ISSUE, S_WAIT: begin
        bus.Mem_Enable         = 1'b1;
        bus.Mem_Read_H_Write_L = ~write_q;
        bus.Stall              = 1'b1;
      end
      S_DONE: begin
        bus.Req_Done  = 1'b1;
        bus.Req_Error = error_q;
      end
      default: begin
        bus.Stall = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_memory_access_sequencer.sv
// tb/tb_memory_access_sequencer.sv - scoreboard bench for memory_access_sequencer

module tb_memory_access_sequencer;

  localparam int TO = 15;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic Clock;
  logic Reset_L;
  int   cyc;
  int   vectors;
  int   miscompares;
  exp_t sb[$];
  exp_t mon_e;
  logic [31:0] rd_model;

  memory_access_sequencer_if bus();

  memory_access_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .Clock   (Clock),
    .Reset_L (Reset_L),
    .bus     (bus.master)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every Req_Done pops one expected completion.
  always @(negedge Clock) begin
    if (bus.Req_Done === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done at cycle %0d: got Req_Done=1, expected 0", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("done_cycle", 32'(cyc), 32'(mon_e.cyc));
        check("req_error", {31'd0, bus.Req_Error}, {31'd0, mon_e.err});
        check("read_data", bus.Read_Data, mon_e.rdata);
      end
    end else if (bus.Req_Error === 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL stray_error at cycle %0d: got Req_Error=1 without Req_Done, expected 0", cyc);
    end
  end

  // waits: MFC-low WAIT cycles before MFC; negative means MFC never comes.
  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int waits, input logic [31:0] rdata, input bit hold);
    int   c0;
    int   done_c;
    exp_t e;
    @(posedge Clock); #1;
    c0 = cyc;
    bus.Req_Valid   = 1'b1;
    bus.Req_Write   = wr;
    bus.Req_Address = addr;
    bus.Req_Data    = wdata;
    bus.Mem_MFC     = 1'b0;
    done_c = (waits < 0) ? c0 + TO + 2 : c0 + 3 + waits;
    if (waits >= 0 && !wr) rd_model = rdata;
    e.cyc   = done_c;
    e.err   = (waits < 0);
    e.rdata = rd_model;
    sb.push_back(e);
    #1 check("stall_on_request", {31'd0, bus.Stall}, 32'd1);
    while (cyc < done_c) begin
      @(posedge Clock); #1;
      if (cyc == c0 + 2) begin
        bus.Req_Write   = ~wr;
        bus.Req_Address = ~addr;
        bus.Req_Data    = ~wdata;
      end
      bus.Mem_MFC     = (waits >= 0) && (cyc == c0 + 2 + waits);
      bus.Mem_Data_In = bus.Mem_MFC ? rdata : 32'h5A5A_5A5A;
      if (cyc == done_c) begin
        bus.Mem_MFC = 1'b0;
        if (!hold) bus.Req_Valid = 1'b0;
      end
      #1;
      if (cyc < done_c) begin
        check("mem_enable_active", {31'd0, bus.Mem_Enable}, 32'd1);
        check("mem_rhwl_active", {31'd0, bus.Mem_Read_H_Write_L}, {31'd0, ~wr});
        check("mem_address", bus.Mem_Address, addr);
        check("mem_data_out", bus.Mem_Data_Out, wr ? wdata : 32'd0);
        check("stall_active", {31'd0, bus.Stall}, 32'd1);
      end else begin
        check("mem_enable_done", {31'd0, bus.Mem_Enable}, 32'd0);
        check("mem_rhwl_done", {31'd0, bus.Mem_Read_H_Write_L}, 32'd1);
        check("stall_done", {31'd0, bus.Stall}, 32'd0);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    vectors     = 0;
    miscompares = 0;
    rd_model    = 32'd0;
    Reset_L         = 1'b0;
    bus.Req_Valid   = 1'b0;
    bus.Req_Write   = 1'b0;
    bus.Req_Address = 32'd0;
    bus.Req_Data    = 32'd0;
    bus.Mem_Data_In = 32'd0;
    bus.Mem_MFC     = 1'b0;

    // Reset and idle
    repeat (2) @(posedge Clock);
    #1 Reset_L = 1'b1;
    check("reset_mem_address", bus.Mem_Address, 32'd0);
    check("reset_mem_data_out", bus.Mem_Data_Out, 32'd0);
    repeat (5) begin
      @(posedge Clock); #1;
      check("idle_mem_enable", {31'd0, bus.Mem_Enable}, 32'd0);
      check("idle_mem_rhwl", {31'd0, bus.Mem_Read_H_Write_L}, 32'd1);
      check("idle_read_data", bus.Read_Data, 32'd0);
      check("idle_stall", {31'd0, bus.Stall}, 32'd0);
      check("idle_req_done", {31'd0, bus.Req_Done}, 32'd0);
    end

    // Zero-wait load
    access(1'b0, 32'h0000_0010, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
    @(posedge Clock); #1;
    check("load_read_data_after", bus.Read_Data, 32'hDEAD_BEEF);

    // Store with 3 wait cycles, Read_Data untouched
    access(1'b1, 32'h0000_0020, 32'h1234_5678, 3, 32'hFFFF_0000, 1'b0);

    // Timeout
    access(1'b0, 32'h0000_0030, 32'h0, -1, 32'h0, 1'b0);

    // MFC on the timeout cycle
    access(1'b0, 32'h0000_0040, 32'h0, TO - 1, 32'hCAFE_F00D, 1'b0);

    // Reset in the 2nd WAIT cycle
    @(posedge Clock); #1;
    c0 = cyc;
    bus.Req_Valid   = 1'b1;
    bus.Req_Write   = 1'b0;
    bus.Req_Address = 32'h0000_0050;
    while (cyc < c0 + 3) begin
      @(posedge Clock); #1;
    end
    Reset_L       = 1'b0;
    bus.Req_Valid = 1'b0;
    @(posedge Clock); #1;
    Reset_L  = 1'b1;
    rd_model = 32'd0;
    check("abort_mem_enable", {31'd0, bus.Mem_Enable}, 32'd0);
    check("abort_read_data", bus.Read_Data, 32'd0);
    repeat (3) @(posedge Clock);

    // Back-to-back loads, Req_Valid held through the first DONE
    access(1'b0, 32'h0000_0060, 32'h0, 1, 32'h1111_1111, 1'b1);
    access(1'b0, 32'h0000_0064, 32'h0, 0, 32'h2222_2222, 1'b0);

    repeat (5) @(posedge Clock);
    #1 check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
